// File: rtl/dwt_row_sequencer.sv
// Row buffer and op sequencer for a 5/3 lifting stage: loads a row, runs two lifting passes with edge extension, streams it out.
// Out stalls on out_ready, in_ready is low outside LOAD; DWT_SEQ_DEINTERLEAVE_EN selects subband output order.
module dwt_row_sequencer #(
  parameter int ROW_LEN  = 8,
  parameter int DW       = 16,
  parameter int LIFT_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fwd,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] l_s,
  output logic [DW-1:0] r_s,
  output logic [DW-1:0] s_s,
  output logic          e_o_s,
  output logic          f_i_s,
  output logic          op_valid,
  input  logic [DW-1:0] res_s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int IW = $clog2(ROW_LEN);
  localparam int HALF = ROW_LEN / 2;
  localparam logic [IW-1:0] ZERO    = '0;
  localparam logic [IW-1:0] ONE     = IW'(1);
  localparam logic [IW-1:0] LAST_K  = IW'(ROW_LEN - 1);
  localparam logic [IW-1:0] HALF_K  = IW'(HALF);
  localparam logic [IW-1:0] HALF_M1 = IW'(HALF - 1);
  localparam logic [IW-1:0] LAT_M1  = IW'(LIFT_LAT - 1);

  typedef enum logic [2:0] {
    LOAD,
    PASS_A,
    DRAIN_A,
    PASS_B,
    DRAIN_B,
    UNLOAD
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          fwd_q;
  logic [DW-1:0] row_q [ROW_LEN];
  logic          tag_vld_q [LIFT_LAT];
  logic [IW-1:0] tag_idx_q [LIFT_LAT];

  logic          op_odd;
  logic [IW-1:0] op_idx;
  logic [IW-1:0] out_idx;
  logic          in_acc;

  // Forward runs predict first; inverse runs update first.
  assign op_odd = (state_q == PASS_A) ? fwd_q : ~fwd_q;
  assign op_idx = (cnt_q << 1) | IW'(op_odd);
  assign in_acc = in_valid & in_ready;
  assign f_i_s  = fwd_q;
  assign busy   = (state_q != LOAD);

`ifdef DWT_SEQ_DEINTERLEAVE_EN
  assign out_idx = (cnt_q < HALF_K) ? (cnt_q << 1) : (((cnt_q - HALF_K) << 1) | ONE);
`else
  assign out_idx = cnt_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    op_valid  = 1'b0;
    e_o_s     = 1'b0;
    l_s       = '0;
    r_s       = '0;
    s_s       = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_q == LAST_K) begin
            cnt_d   = ZERO;
            state_d = PASS_A;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      PASS_A, PASS_B: begin
        op_valid = 1'b1;
        e_o_s    = op_odd;
        s_s      = row_q[op_idx];
        // Symmetric extension mirrors the missing neighbour onto the existing one.
        if (op_odd) begin
          l_s = row_q[op_idx - ONE];
          r_s = (op_idx == LAST_K) ? row_q[op_idx - ONE] : row_q[op_idx + ONE];
        end else begin
          l_s = (op_idx == ZERO) ? row_q[ONE] : row_q[op_idx - ONE];
          r_s = row_q[op_idx + ONE];
        end
        if (cnt_q == HALF_M1) begin
          cnt_d   = ZERO;
          state_d = (state_q == PASS_A) ? DRAIN_A : DRAIN_B;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DRAIN_A, DRAIN_B: begin
        if (cnt_q == LAT_M1) begin
          cnt_d   = ZERO;
          state_d = (state_q == DRAIN_A) ? PASS_B : UNLOAD;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_data  = row_q[out_idx];
        out_last  = (cnt_q == LAST_K);
        if (out_ready) begin
          if (cnt_q == LAST_K) begin
            cnt_d   = ZERO;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= ZERO;
      fwd_q   <= 1'b0;
      for (int i = 0; i < LIFT_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_idx_q[i] <= ZERO;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_acc && (cnt_q == ZERO)) begin
        fwd_q <= fwd;
      end
      tag_vld_q[0] <= op_valid;
      tag_idx_q[0] <= op_idx;
      for (int i = 1; i < LIFT_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  // Row storage is deliberately not reset; every LOAD overwrites all entries.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      row_q[cnt_q] <= in_data;
    end
    if (tag_vld_q[LIFT_LAT-1]) begin
      row_q[tag_idx_q[LIFT_LAT-1]] <= res_s;
    end
  end

endmodule
